// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out audio transmitter.
// Left/right sample pairs enter through a valid/ready handshake into a
// one-deep holding buffer. They are then shifted out MSB-first on OutL/OutR
// with a one-cycle Frame marker on the MSB. MIN_GAP idle cycles are inserted
// between frames, and MIN_GAP=0 gives gapless streaming.

module piso_tx #(
  parameter int WIDTH   = 16,
  parameter int MIN_GAP = 0
) (
  input  logic             Dclk,
  input  logic             Clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] InputL,
  input  logic [WIDTH-1:0] InputR,
  output logic             in_ready,
  output logic             Frame,
  output logic             OutL,
  output logic             OutR,
  output logic             underrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_TOP = (MIN_GAP > 0) ? GW'(MIN_GAP - 1) : GW'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_hold_l;
  logic [WIDTH-1:0] r_hold_r;
  logic [WIDTH-1:0] r_shift_l;
  logic [WIDTH-1:0] r_shift_r;
  logic [CW-1:0]    r_bitcnt;
  logic [GW-1:0]    r_gapcnt;
  logic             r_frame;
  logic             r_out_l;
  logic             r_out_r;
  logic             r_underrun;

  state_t           w_next_state;
  logic             w_accept;
  logic             w_load;
  logic             w_shift;
  logic             w_end;
  logic             w_gap_start;
  logic             w_gap_dec;
  logic [WIDTH-1:0] w_shift_l_nxt;
  logic [WIDTH-1:0] w_shift_r_nxt;
  logic [CW-1:0]    w_bitcnt_nxt;
  logic [GW-1:0]    w_gapcnt_nxt;
  logic             w_frame_nxt;
  logic             w_out_l_nxt;
  logic             w_out_r_nxt;
  logic             w_underrun_nxt;

  // Ready depends only on registered buffer state and Clear, so in_valid has no combinational path to it.
  assign in_ready = !Clear && !r_hold_full;
  assign w_accept = in_valid && in_ready;

  assign Frame    = r_frame;
  assign OutL     = r_out_l;
  assign OutR     = r_out_r;
  assign underrun = r_underrun;

  // Next-state and control decode: frame start, bit shift, frame end and gap counting.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_end        = 1'b0;
    w_gap_start  = 1'b0;
    w_gap_dec    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_load       = 1'b1;
          w_next_state = ST_SHIFT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_bitcnt != {CW{1'b0}}) begin
          w_shift      = 1'b1;
          w_next_state = ST_SHIFT;
        end else begin
          // Edge after bit 0: the frame is complete.
          w_end = 1'b1;
          if ((MIN_GAP == 0) && r_hold_full) begin
            w_load       = 1'b1;
            w_next_state = ST_SHIFT;
          end else if (MIN_GAP > 0) begin
            w_gap_start  = 1'b1;
            w_next_state = ST_GAP;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (r_gapcnt != {GW{1'b0}}) begin
          w_gap_dec    = 1'b1;
          w_next_state = ST_GAP;
        end else if (r_hold_full) begin
          w_load       = 1'b1;
          w_next_state = ST_SHIFT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: shifters, counters and the serial/marker outputs.
  always_comb begin
    w_shift_l_nxt  = r_shift_l;
    w_shift_r_nxt  = r_shift_r;
    w_bitcnt_nxt   = r_bitcnt;
    w_gapcnt_nxt   = r_gapcnt;
    w_frame_nxt    = 1'b0;
    w_out_l_nxt    = 1'b0;
    w_out_r_nxt    = 1'b0;
    w_underrun_nxt = w_end && !r_hold_full;
    if (w_load) begin
      w_shift_l_nxt = r_hold_l;
      w_shift_r_nxt = r_hold_r;
      w_bitcnt_nxt  = CNT_TOP;
      w_frame_nxt   = 1'b1;
      w_out_l_nxt   = r_hold_l[WIDTH-1];
      w_out_r_nxt   = r_hold_r[WIDTH-1];
    end else if (w_shift) begin
      w_shift_l_nxt = {r_shift_l[WIDTH-2:0], 1'b0};
      w_shift_r_nxt = {r_shift_r[WIDTH-2:0], 1'b0};
      w_bitcnt_nxt  = r_bitcnt - CW'(1);
      w_out_l_nxt   = r_shift_l[WIDTH-2];
      w_out_r_nxt   = r_shift_r[WIDTH-2];
    end else begin
      w_shift_l_nxt = r_shift_l;
      w_shift_r_nxt = r_shift_r;
    end
    if (w_gap_start) begin
      w_gapcnt_nxt = GAP_TOP;
    end else if (w_gap_dec) begin
      w_gapcnt_nxt = r_gapcnt - GW'(1);
    end else begin
      w_gapcnt_nxt = r_gapcnt;
    end
  end

  // FSM state register.
  always_ff @(posedge Dclk) begin
    if (Clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Holding buffer: a new accept wins over the drain into the shifter, so the new pair stays queued.
  always_ff @(posedge Dclk) begin
    if (Clear) begin
      r_hold_full <= 1'b0;
      r_hold_l    <= {WIDTH{1'b0}};
      r_hold_r    <= {WIDTH{1'b0}};
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_l    <= InputL;
      r_hold_r    <= InputR;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end else begin
      r_hold_full <= r_hold_full;
    end
  end

  // Shifters, counters and registered outputs; Clear drops any frame in flight.
  always_ff @(posedge Dclk) begin
    if (Clear) begin
      r_shift_l  <= {WIDTH{1'b0}};
      r_shift_r  <= {WIDTH{1'b0}};
      r_bitcnt   <= CNT_TOP;
      r_gapcnt   <= {GW{1'b0}};
      r_frame    <= 1'b0;
      r_out_l    <= 1'b0;
      r_out_r    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_shift_l  <= w_shift_l_nxt;
      r_shift_r  <= w_shift_r_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_gapcnt   <= w_gapcnt_nxt;
      r_frame    <= w_frame_nxt;
      r_out_l    <= w_out_l_nxt;
      r_out_r    <= w_out_r_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: bench for piso_tx. It runs two instances side by side,
// one with MIN_GAP=0 and one with MIN_GAP=2. Each instance is checked
// against a frame-window reference model on every cycle, and a set of
// hand-computed literal checks pins the expected behaviour.

module tb_piso_tx;
  localparam int W  = 16;
  localparam int G0 = 0;
  localparam int G2 = 2;

  logic Dclk = 1'b0;
  logic Clear = 1'b1;
  logic in_valid = 1'b0;
  logic [W-1:0] InputL = '0;
  logic [W-1:0] InputR = '0;
  logic in_ready0, Frame0, OutL0, OutR0, underrun0;
  logic in_ready2, Frame2, OutL2, OutR2, underrun2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state, per instance (index 0: MIN_GAP=0, index 1: MIN_GAP=2).
  bit           m_full [2];
  logic [W-1:0] m_hl   [2];
  logic [W-1:0] m_hr   [2];
  bit           m_act  [2];
  int           m_s    [2];
  logic [W-1:0] m_fl   [2];
  logic [W-1:0] m_fr   [2];
  int           m_earl [2];
  bit e_frame [2];
  bit e_l     [2];
  bit e_r     [2];
  bit e_und   [2];

  always #5 Dclk = ~Dclk;

  piso_tx #(.WIDTH(W), .MIN_GAP(G0)) dut0 (
    .Dclk(Dclk), .Clear(Clear), .in_valid(in_valid), .InputL(InputL), .InputR(InputR),
    .in_ready(in_ready0), .Frame(Frame0), .OutL(OutL0), .OutR(OutR0), .underrun(underrun0));

  piso_tx #(.WIDTH(W), .MIN_GAP(G2)) dut2 (
    .Dclk(Dclk), .Clear(Clear), .in_valid(in_valid), .InputL(InputL), .InputR(InputR),
    .in_ready(in_ready2), .Frame(Frame2), .OutL(OutL2), .OutR(OutR2), .underrun(underrun2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // A frame occupies edges S..S+W-1. The edge S+W reports underrun if nothing is waiting.
  // The next frame may start at the first edge >= S+W+gap on which the buffer is full.
  task automatic model_step(input int k, input int t);
    bit pre_full;
    bit st;
    int gap;
    gap = (k == 0) ? G0 : G2;
    e_frame[k] = 1'b0; e_l[k] = 1'b0; e_r[k] = 1'b0; e_und[k] = 1'b0;
    if (Clear) begin
      m_full[k] = 1'b0;
      m_act[k]  = 1'b0;
      m_earl[k] = 0;
    end else begin
      pre_full = m_full[k];
      if (m_act[k] && (t == m_s[k] + W)) e_und[k] = !pre_full;
      st = pre_full && (t >= m_earl[k]);
      if (st) begin
        m_act[k]  = 1'b1;
        m_s[k]    = t;
        m_fl[k]   = m_hl[k];
        m_fr[k]   = m_hr[k];
        m_full[k] = 1'b0;
        m_earl[k] = t + W + gap;
      end
      if (m_act[k] && (t - m_s[k] < W)) begin
        e_frame[k] = (t == m_s[k]);
        e_l[k]     = m_fl[k][W-1-(t-m_s[k])];
        e_r[k]     = m_fr[k][W-1-(t-m_s[k])];
      end
      if (in_valid && !pre_full) begin
        m_hl[k]   = InputL;
        m_hr[k]   = InputR;
        m_full[k] = 1'b1;
      end
    end
  endtask

  // Model advances on every rising edge using the inputs that were stable across it.
  initial begin
    forever begin
      @(posedge Dclk);
      cyc++;
      model_step(0, cyc);
      model_step(1, cyc);
    end
  end

  // Per-cycle comparison of both instances against the model, away from the edge.
  initial begin
    forever begin
      @(posedge Dclk);
      #2;
      chk("ready0",    in_ready0, !Clear && !m_full[0]);
      chk("frame0",    Frame0,    e_frame[0]);
      chk("outl0",     OutL0,     e_l[0]);
      chk("outr0",     OutR0,     e_r[0]);
      chk("underrun0", underrun0, e_und[0]);
      chk("ready2",    in_ready2, !Clear && !m_full[1]);
      chk("frame2",    Frame2,    e_frame[1]);
      chk("outl2",     OutL2,     e_l[1]);
      chk("outr2",     OutR2,     e_r[1]);
      chk("underrun2", underrun2, e_und[1]);
    end
  end

  // Send one pair into an idle instance 0 and capture what it serialises.
  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                            output logic [W-1:0] cl, output logic [W-1:0] cr,
                            output int fr_n, output int fr_at, output int un_n, output int un_at);
    cl = '0; cr = '0; fr_n = 0; fr_at = -1; un_n = 0; un_at = -1;
    @(negedge Dclk);
    chk("send_ready", in_ready0, 1);
    in_valid = 1'b1; InputL = l; InputR = r;
    @(negedge Dclk);
    in_valid = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge Dclk);
      if (Frame0)    begin fr_n++; fr_at = j; end
      if (underrun0) begin un_n++; un_at = j; end
      if (j <= W) begin
        cl[W-j] = OutL0;
        cr[W-j] = OutR0;
      end
    end
  endtask

  logic [W-1:0] cl, cr;
  int fr_n, fr_at, un_n, un_at;
  int q0[$];
  int q2[$];
  int uq[$];
  int idx, quiet;
  logic rdy;
  logic [W-1:0] bl [3];

  initial begin
    bl[0] = 16'h8001; bl[1] = 16'hFFFF; bl[2] = 16'h0000;

    // Reset held for three cycles while the producer offers data.
    Clear = 1'b1; in_valid = 1'b1; InputL = 16'h5555; InputR = 16'hAAAA;
    repeat (3) begin
      @(negedge Dclk);
      chk("rst_ready", in_ready0, 0);
      chk("rst_frame", Frame0, 0);
      chk("rst_out",   {OutL0, OutR0, underrun0}, 0);
    end
    Clear = 1'b0; in_valid = 1'b0;
    @(negedge Dclk);
    chk("rel_ready", in_ready0, 1);

    // Single frame.
    send_frame(16'hA5C3, 16'h0F0F, cl, cr, fr_n, fr_at, un_n, un_at);
    chk("sf_outl",   cl, 16'hA5C3);
    chk("sf_outr",   cr, 16'h0F0F);
    chk("sf_frames", fr_n, 1);
    chk("sf_frame_at", fr_at, 1);
    chk("sf_und_n",  un_n, 1);
    chk("sf_und_at", un_at, 17);

    // Back-to-back with in_valid held; the data advances on each accept seen by instance 0.
    repeat (10) @(negedge Dclk);
    idx = 0; in_valid = 1'b1; InputL = bl[0]; InputR = ~bl[0];
    for (int c = 0; c < 80; c++) begin
      rdy = in_ready0;
      @(negedge Dclk);
      if (Frame0)    q0.push_back(c);
      if (underrun0) uq.push_back(c);
      if (in_valid && rdy) begin
        idx++;
        if (idx < 3) begin InputL = bl[idx]; InputR = ~bl[idx]; end
        else in_valid = 1'b0;
      end
    end
    chk("b2b_frames", q0.size(), 3);
    if (q0.size() == 3) begin
      chk("b2b_period1", q0[1] - q0[0], 16);
      chk("b2b_period2", q0[2] - q0[1], 16);
      chk("b2b_und_n", uq.size(), 1);
      if (uq.size() == 1) chk("b2b_und_at", uq[0] - q0[2], 16);
    end

    // Continuous valid: period 16 without gap, 18 with a two-cycle gap.
    repeat (50) @(negedge Dclk);
    q0.delete(); q2.delete();
    for (int c = 0; c < 100; c++) begin
      @(negedge Dclk);
      in_valid = 1'b1; InputL = W'($urandom); InputR = W'($urandom);
      if (Frame0) q0.push_back(c);
      if (Frame2) q2.push_back(c);
    end
    in_valid = 1'b0;
    chk("cont_n0", q0.size() >= 5, 1);
    chk("cont_n2", q2.size() >= 4, 1);
    for (int i = 1; i < q0.size(); i++) chk("cont_period0", q0[i] - q0[i-1], 16);
    for (int i = 1; i < q2.size(); i++) chk("cont_period2", q2[i] - q2[i-1], 18);

    // Clear in the middle of a frame, then a clean restart.
    repeat (50) @(negedge Dclk);
    @(negedge Dclk);
    in_valid = 1'b1; InputL = 16'hFFFF; InputR = 16'hFFFF;
    @(negedge Dclk);
    in_valid = 1'b0;
    repeat (9) @(negedge Dclk);
    chk("mc_bit7", OutL0, 1);
    Clear = 1'b1;
    @(negedge Dclk);
    chk("mc_frame", Frame0, 0);
    chk("mc_outl",  OutL0, 0);
    chk("mc_outr",  OutR0, 0);
    chk("mc_ready", in_ready0, 0);
    Clear = 1'b0;
    quiet = 0;
    repeat (20) begin
      @(negedge Dclk);
      quiet += int'(OutL0) + int'(OutR0) + int'(Frame0) + int'(underrun0);
    end
    chk("mc_quiet", quiet, 0);
    send_frame(16'h1234, 16'hEDCB, cl, cr, fr_n, fr_at, un_n, un_at);
    chk("mc_outl_new", cl, 16'h1234);
    chk("mc_outr_new", cr, 16'hEDCB);
    chk("mc_frame_at", fr_at, 1);
    chk("mc_frames",   fr_n, 1);

    // Randomised traffic with occasional Clear, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge Dclk);
      in_valid = ($urandom_range(0, 3) != 0);
      InputL   = W'($urandom);
      InputR   = W'($urandom);
      Clear    = ($urandom_range(0, 149) == 0);
    end
    Clear = 1'b0; in_valid = 1'b0;
    repeat (40) @(negedge Dclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
